// File: rtl/adaptive_threshold_sequencer.sv
// Two-pass frame controller: box filter, then threshold, with per-stage watchdog and frame counter.
// Optional ADAPTIVE_THRESHOLD_AUTO_START_EN: one-shot internal start on the first clock after reset.
module adaptive_threshold_sequencer #(
  parameter int WIDTH_BITS     = 8,
  parameter int HEIGHT_BITS    = 8,
  parameter int TIMEOUT_CYCLES = 131072,
  parameter int FRAME_BITS     = 8
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic                   iStart,
  input  logic                   iContinuous,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError,
  output logic [FRAME_BITS-1:0]  oFrameCount,
  output logic                   oBoxStart,
  input  logic                   iBoxFinished,
  output logic                   oThrStart,
  input  logic                   iThrFinished,
  input  logic [WIDTH_BITS-1:0]  iBoxImageCol,
  input  logic [HEIGHT_BITS-1:0] iBoxImageRow,
  input  logic [WIDTH_BITS-1:0]  iThrImageCol,
  input  logic [HEIGHT_BITS-1:0] iThrImageRow,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  output logic [9:0]             oStatus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BOX_START, S_BOX_RUN, S_THR_START, S_THR_RUN, S_DONE, S_ERROR
  } state_t;

  state_t                 r_state, w_next;
  logic [WD_W-1:0]        r_wd, w_wd_next;
  logic                   r_busy, r_done, r_error, r_box_start, r_thr_start;
  logic [FRAME_BITS-1:0]  r_frame_count;
  logic [9:0]             r_status, w_status;
  logic [4:0]             w_fc5;
  logic                   w_start;

`ifdef ADAPTIVE_THRESHOLD_AUTO_START_EN
  logic r_auto_start;
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) r_auto_start <= 1'b1;
    else            r_auto_start <= 1'b0;
  end
  assign w_start = iStart | r_auto_start;
`else
  assign w_start = iStart;
`endif

  // A zero watchdog marks the first run cycle, where the stale finished level is ignored.
  always_comb begin
    w_next    = r_state;
    w_wd_next = r_wd;
    case (r_state)
      S_IDLE:      if (w_start) w_next = S_BOX_START;
      S_BOX_START: begin
        w_next    = S_BOX_RUN;
        w_wd_next = '0;
      end
      S_BOX_RUN: begin
        if (r_wd != '0 && iBoxFinished) w_next = S_THR_START;
        else if (r_wd == WD_LAST)       w_next = S_ERROR;
        else                            w_wd_next = r_wd + WD_W'(1);
      end
      S_THR_START: begin
        w_next    = S_THR_RUN;
        w_wd_next = '0;
      end
      S_THR_RUN: begin
        if (r_wd != '0 && iThrFinished) w_next = S_DONE;
        else if (r_wd == WD_LAST)       w_next = S_ERROR;
        else                            w_wd_next = r_wd + WD_W'(1);
      end
      S_DONE:      w_next = (iContinuous || w_start) ? S_BOX_START : S_IDLE;
      S_ERROR:     if (w_start) w_next = S_BOX_START;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_fc5    = 5'(r_frame_count);
    w_status = {r_error, w_fc5, r_state == S_DONE,
                (r_state == S_THR_START) || (r_state == S_THR_RUN),
                (r_state == S_BOX_START) || (r_state == S_BOX_RUN),
                r_state == S_IDLE};
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_state       <= S_IDLE;
      r_wd          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_box_start   <= 1'b0;
      r_thr_start   <= 1'b0;
      r_frame_count <= '0;
      r_status      <= 10'b0000000001;
    end else begin
      r_state     <= w_next;
      r_wd        <= w_wd_next;
      r_busy      <= (w_next == S_BOX_START) || (w_next == S_BOX_RUN) ||
                     (w_next == S_THR_START) || (w_next == S_THR_RUN);
      r_done      <= (w_next == S_DONE);
      r_error     <= (w_next == S_ERROR);
      r_box_start <= (w_next == S_BOX_START);
      r_thr_start <= (w_next == S_THR_START);
      if (w_next == S_DONE) r_frame_count <= r_frame_count + FRAME_BITS'(1);
      r_status    <= w_status;
    end
  end

  always_comb begin
    oImageCol = iBoxImageCol;
    oImageRow = iBoxImageRow;
    if (r_state == S_THR_START || r_state == S_THR_RUN) begin
      oImageCol = iThrImageCol;
      oImageRow = iThrImageRow;
    end
  end

  assign oBusy       = r_busy;
  assign oDone       = r_done;
  assign oError      = r_error;
  assign oFrameCount = r_frame_count;
  assign oBoxStart   = r_box_start;
  assign oThrStart   = r_thr_start;
  assign oStatus     = r_status;

endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// Randomized bench for adaptive_threshold_sequencer; expected per-cycle phases come from a frame-level timing model.
module tb_adaptive_threshold_sequencer;

  localparam int WB = 8;
  localparam int HB = 8;
  localparam int TO = 16;
  localparam int FB = 2;

  localparam int PH_IDLE = 0, PH_BS = 1, PH_BR = 2, PH_TS = 3, PH_TR = 4, PH_DONE = 5, PH_ERR = 6;

  logic          clock = 1'b0;
  logic          not_reset;
  logic          iStart, iContinuous, iBoxFinished, iThrFinished;
  logic          oBusy, oDone, oError, oBoxStart, oThrStart;
  logic [FB-1:0] oFrameCount;
  logic [WB-1:0] iBoxImageCol, iThrImageCol, oImageCol;
  logic [HB-1:0] iBoxImageRow, iThrImageRow, oImageRow;
  logic [9:0]    oStatus;

  int checks = 0;
  int errors = 0;
  int prev_ph, prev_fc, exp_fc;

  adaptive_threshold_sequencer #(
    .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .TIMEOUT_CYCLES(TO), .FRAME_BITS(FB)
  ) dut (
    .clock(clock), .not_reset(not_reset), .iStart(iStart), .iContinuous(iContinuous),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oFrameCount(oFrameCount),
    .oBoxStart(oBoxStart), .iBoxFinished(iBoxFinished),
    .oThrStart(oThrStart), .iThrFinished(iThrFinished),
    .iBoxImageCol(iBoxImageCol), .iBoxImageRow(iBoxImageRow),
    .iThrImageCol(iThrImageCol), .iThrImageRow(iThrImageRow),
    .oImageCol(oImageCol), .oImageRow(oImageRow), .oStatus(oStatus)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Compare every output against the phase the model says this cycle belongs to.
  task automatic check_cycle(input int ph);
    logic [9:0] es;
    logic       thr;
    thr = (ph == PH_TS) || (ph == PH_TR);
    es = {prev_ph == PH_ERR, 5'(prev_fc), prev_ph == PH_DONE,
          (prev_ph == PH_TS) || (prev_ph == PH_TR),
          (prev_ph == PH_BS) || (prev_ph == PH_BR), prev_ph == PH_IDLE};
    chk_eq("box_start", 32'(oBoxStart), 32'(ph == PH_BS));
    chk_eq("thr_start", 32'(oThrStart), 32'(ph == PH_TS));
    chk_eq("busy",      32'(oBusy),     32'((ph >= PH_BS) && (ph <= PH_TR)));
    chk_eq("done",      32'(oDone),     32'(ph == PH_DONE));
    chk_eq("error",     32'(oError),    32'(ph == PH_ERR));
    chk_eq("frame_cnt", 32'(oFrameCount), 32'(exp_fc));
    chk_eq("status",    32'(oStatus),   32'(es));
    chk_eq("img_col",   32'(oImageCol), 32'(thr ? iThrImageCol : iBoxImageCol));
    chk_eq("img_row",   32'(oImageRow), 32'(thr ? iThrImageRow : iBoxImageRow));
    prev_ph = ph;
    prev_fc = exp_fc;
    iBoxImageCol = WB'($urandom);
    iBoxImageRow = HB'($urandom);
    iThrImageCol = WB'($urandom);
    iThrImageRow = HB'($urandom);
  endtask

  task automatic set_fin(input int sp, input logic v);
    if (sp == PH_BS) iBoxFinished = v;
    else             iThrFinished = v;
  endtask

  task automatic do_async_reset();
    #2 not_reset = 1'b0;
    iStart = 1'b0;
    iContinuous = 1'b0;
    #1;
    prev_ph = PH_IDLE;
    prev_fc = 0;
    exp_fc  = 0;
    check_cycle(PH_IDLE);
  endtask

  // Finished held low for the first d run cycles, then high. Accepted on run cycle max(1,d)
  // if that is within the watchdog window, otherwise the stage runs TO cycles and errors.
  task automatic stage(input int sp, input int d, input int abort_at, output int res);
    int n;
    res = 0;
    @(negedge clock);
    check_cycle(sp);
    set_fin(sp, d == 0);
    iStart = 1'($urandom_range(3) == 0);
    iContinuous = 1'($urandom_range(1));
    n = (d <= TO - 1) ? (((d < 1) ? 1 : d) + 1) : TO;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check_cycle(sp + 1);
      set_fin(sp, k >= d);
      iStart = 1'($urandom_range(3) == 0);
      if (k == abort_at) begin
        do_async_reset();
        res = 2;
        return;
      end
    end
    if (d > TO - 1) res = 1;
  endtask

  task automatic frame(input int db, input int dt, input int abort_at, output int res);
    stage(PH_BS, db, -1, res);
    if (res == 0) stage(PH_TS, dt, abort_at, res);
    if (res == 1) begin
      @(negedge clock);
      check_cycle(PH_ERR);
    end else if (res == 0) begin
      @(negedge clock);
      exp_fc = (exp_fc + 1) % (1 << FB);
      check_cycle(PH_DONE);
    end
    iStart = 1'b0;
  endtask

  task automatic idle(input int n, input int ph);
    for (int i = 0; i < n; i++) begin
      iStart = 1'b0;
      iContinuous = 1'b0;
      @(negedge clock);
      check_cycle(ph);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int res, cur;
    logic s, c;
    not_reset = 1'b0;
    iStart = 1'b0; iContinuous = 1'b0; iBoxFinished = 1'b0; iThrFinished = 1'b0;
    iBoxImageCol = 8'h12; iBoxImageRow = 8'h34; iThrImageCol = 8'hAB; iThrImageRow = 8'hCD;
    prev_ph = PH_IDLE; prev_fc = 0; exp_fc = 0;
    idle(2, PH_IDLE);
    not_reset = 1'b1;
    idle(2, PH_IDLE);

    // single frame
    iStart = 1'b1; frame(10, 12, -1, res);
    idle(3, PH_IDLE);
    // stale finished on both stages
    iStart = 1'b1; frame(0, 0, -1, res);
    idle(1, PH_IDLE);
    // threshold timeout, linger in ERROR, restart with finished on the last window cycle
    iStart = 1'b1; frame(3, TO + 4, -1, res);
    idle(2, PH_ERR);
    iStart = 1'b1; frame(TO - 1, 5, -1, res);
    idle(1, PH_IDLE);
    // box timeout at exactly the window length
    iStart = 1'b1; frame(TO, 0, -1, res);
    iStart = 1'b1; frame(1, 1, -1, res);
    idle(1, PH_IDLE);
    // reset mid-frame during threshold run
    iStart = 1'b1; frame(2, 10, 4, res);
    idle(2, PH_IDLE);
    not_reset = 1'b1;
    idle(2, PH_IDLE);
    // continuous mode, five back-to-back frames
    for (int i = 0; i < 5; i++) begin
      iStart = (i == 0);
      iContinuous = 1'b1;
      frame(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), -1, res);
    end
    idle(2, PH_IDLE);

    // random frames, gaps and restarts
    cur = PH_IDLE;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(2) == 0);
      c = 1'($urandom_range(1));
      iStart = s;
      iContinuous = c;
      if (s || (cur == PH_DONE && c)) begin
        frame(int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 1)), -1, res);
        cur = (res == 1) ? PH_ERR : PH_DONE;
      end else begin
        @(negedge clock);
        cur = (cur == PH_ERR) ? PH_ERR : PH_IDLE;
        check_cycle(cur);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
